// File: rtl/mem_bus_pkg.sv
// Shared definitions for the pipeline-to-bus memory master: state encoding,
// default base address and word-address width.
package mem_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'd1024;
    localparam int          WORD_ADDR_W       = 30;

    // Byte address relative to base, converted to a zero-extended word address.
    function automatic logic [31:0] word_addr(input logic [31:0] byte_addr,
                                              input logic [31:0] base);
        logic [31:0] offset;
        offset = byte_addr - base;
        return {{(32 - WORD_ADDR_W){1'b0}}, offset[31:32-WORD_ADDR_W]};
    endfunction

endpackage

// File: rtl/mem_bus_timeout.sv
// Request-phase watchdog: counts REQ cycles without acknowledge and flags the
// cycle in which the count would reach TIMEOUT_CYCLES.
module mem_bus_timeout #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic active,
    input  logic ack,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] count;

    // Expiry fires during the last permitted unacknowledged cycle so the FSM
    // leaves REQ on the same edge the count hits TIMEOUT_CYCLES.
    assign expire = active && !ack && (count == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (start) begin
            count <= '0;
        end else if (active && !ack) begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/mem_bus_master.sv
// Converts pipeline load/store requests into single bus transactions.
// Define MEM_BUS_TIMEOUT_EN to abort requests that wait TIMEOUT_CYCLES without ack.
module mem_bus_master
    import mem_bus_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR      = DEFAULT_BASE_ADDR,
    parameter int          TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_r_en,
    input  logic        mem_w_en,
    input  logic [31:0] alu_res,
    input  logic [31:0] val_rm,
    output logic [31:0] out,
    output logic        ready,
    output logic        err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    state_t      state;
    state_t      state_next;
    logic [31:0] rdata_q;
    logic        start;
    logic        timeout_hit;

    assign start = (state == IDLE) && (mem_r_en || mem_w_en);

`ifdef MEM_BUS_TIMEOUT_EN
    logic err_q;

    mem_bus_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .active(state == REQ),
        .ack   (bus_ack),
        .expire(timeout_hit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= timeout_hit;
        end
    end

    assign err = err_q;
`else
    assign timeout_hit = 1'b0;
    assign err         = 1'b0;
`endif

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (mem_r_en || mem_w_en) state_next = REQ;
            REQ:     if (bus_ack || timeout_hit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Bus fields are latched only when a request launches and then held,
    // so the responder sees stable values for the whole REQ phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            rdata_q   <= '0;
        end else begin
            state   <= state_next;
            bus_req <= (state_next == REQ);
            if (start) begin
                bus_addr  <= word_addr(alu_res, BASE_ADDR);
                bus_we    <= mem_w_en;
                bus_wdata <= val_rm;
            end
            if (state == REQ && bus_ack && !bus_we) begin
                rdata_q <= bus_rdata;
            end else if (timeout_hit) begin
                rdata_q <= '0;
            end
        end
    end

    assign ready = (state == DONE) || (state == IDLE && !mem_r_en && !mem_w_en);
    assign out   = mem_r_en ? rdata_q : 32'b0;

endmodule

// File: tb/tb_mem_bus_master.sv
// Self-checking bench for mem_bus_master: transaction-level model plus
// directed scenarios with hand-computed expectations.
module tb_mem_bus_master;

    localparam logic [31:0] BASE = 32'd1024;
    localparam int          TMO  = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_r_en = 1'b0;
    logic        mem_w_en = 1'b0;
    logic [31:0] alu_res = '0;
    logic [31:0] val_rm = '0;
    logic [31:0] out;
    logic        ready;
    logic        err;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = '0;

    int vectors = 0;
    int miscompares = 0;
    bit checking = 1'b0;

    mem_bus_master #(
        .BASE_ADDR     (BASE),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .mem_r_en (mem_r_en),
        .mem_w_en (mem_w_en),
        .alu_res  (alu_res),
        .val_rm   (val_rm),
        .out      (out),
        .ready    (ready),
        .err      (err),
        .bus_req  (bus_req),
        .bus_we   (bus_we),
        .bus_addr (bus_addr),
        .bus_wdata(bus_wdata),
        .bus_ack  (bus_ack),
        .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Transaction-level model: an access is either in flight, just finished, or absent.
    bit          m_busy = 1'b0;
    bit          m_done = 1'b0;
    bit          m_err = 1'b0;
    bit          m_we = 1'b0;
    int          m_wait = 0;
    logic [31:0] m_addr = '0;
    logic [31:0] m_wdata = '0;
    logic [31:0] m_rdata = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_busy = 0; m_done = 0; m_err = 0; m_we = 0;
            m_addr = '0; m_wdata = '0; m_rdata = '0; m_wait = 0;
        end else if (m_busy) begin
            if (bus_ack) begin
                m_busy = 0;
                m_done = 1;
                if (!m_we) m_rdata = bus_rdata;
            end else begin
                m_wait++;
`ifdef MEM_BUS_TIMEOUT_EN
                if (m_wait == TMO) begin
                    m_busy = 0; m_done = 1; m_err = 1; m_rdata = '0;
                end
`endif
            end
        end else if (m_done) begin
            m_done = 0;
            m_err = 0;
        end else if (mem_r_en || mem_w_en) begin
            m_busy  = 1;
            m_wait  = 0;
            m_addr  = (alu_res - BASE) >> 2;
            m_we    = mem_w_en;
            m_wdata = val_rm;
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            checkOutput("cmp bus_req", bus_req, m_busy);
            checkOutput("cmp bus_we", bus_we, m_we);
            checkOutput("cmp bus_addr", bus_addr, m_addr);
            checkOutput("cmp bus_wdata", bus_wdata, m_wdata);
            checkOutput("cmp ready", ready, m_done || (!m_busy && !mem_r_en && !mem_w_en));
            checkOutput("cmp out", out, mem_r_en ? m_rdata : 32'h0);
            checkOutput("cmp err", err, m_err);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic r, input logic w, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic ack, input logic [31:0] rdata);
        mem_r_en  = r;
        mem_w_en  = w;
        alu_res   = addr;
        val_rm    = wdata;
        bus_ack   = ack;
        bus_rdata = rdata;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got hang, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        int low;

        // Reset state
        step(); step();
        @(negedge clk);
        checkOutput("reset bus_req", bus_req, 1'b0);
        checkOutput("reset out", out, 32'h0);
        checkOutput("reset err", err, 1'b0);
        checkOutput("reset ready", ready, 1'b1);
        checkOutput("reset bus_addr", bus_addr, 32'h0);
        step();
        rst = 1'b0;
        checking = 1'b1;

        // Read, immediate ack
        applyStimulus(1, 0, 32'd1032, 0, 0, 0);
        @(negedge clk); checkOutput("rd req ready", ready, 1'b0);
        step(); applyStimulus(1, 0, 32'd1032, 0, 1, 32'hCAFE0001);
        @(negedge clk);
        checkOutput("rd bus_req", bus_req, 1'b1);
        checkOutput("rd bus_addr", bus_addr, 32'd2);
        checkOutput("rd ready low", ready, 1'b0);
        step(); applyStimulus(1, 0, 32'd1032, 0, 0, 0);
        @(negedge clk);
        checkOutput("rd done ready", ready, 1'b1);
        checkOutput("rd out", out, 32'hCAFE0001);
        step(); applyStimulus(0, 0, 0, 0, 0, 0);
        @(negedge clk); checkOutput("idle ready", ready, 1'b1);

        // Write, ack in 4th REQ cycle
        step(); applyStimulus(0, 1, 32'd1024, 32'h12345678, 0, 0);
        for (int i = 1; i <= 4; i++) begin
            step();
            applyStimulus(0, 1, 32'd1024, 32'h12345678, (i == 4), 0);
            @(negedge clk);
            checkOutput("wr bus_we", bus_we, 1'b1);
            checkOutput("wr bus_addr", bus_addr, 32'd0);
            checkOutput("wr bus_wdata", bus_wdata, 32'h12345678);
            checkOutput("wr ready low", ready, 1'b0);
        end
        step(); applyStimulus(0, 1, 32'd1024, 32'h12345678, 0, 0);
        @(negedge clk); checkOutput("wr done ready", ready, 1'b1);
        step(); applyStimulus(0, 0, 0, 0, 0, 0);

        // Both enables: write wins, read data register untouched
        step(); applyStimulus(1, 1, 32'd1028, 32'hAAAA5555, 0, 0);
        step(); applyStimulus(1, 1, 32'd1028, 32'hAAAA5555, 1, 32'hDEADBEEF);
        @(negedge clk);
        checkOutput("both bus_we", bus_we, 1'b1);
        checkOutput("both bus_addr", bus_addr, 32'd1);
        step(); applyStimulus(1, 1, 32'd1028, 32'hAAAA5555, 0, 0);
        @(negedge clk);
        checkOutput("both out kept", out, 32'hCAFE0001);
        step(); applyStimulus(0, 0, 0, 0, 0, 0);

        // Reset during the second REQ cycle, late ack afterwards
        step(); applyStimulus(1, 0, 32'd1040, 0, 0, 0);
        step();
        step(); rst = 1'b1;
        @(negedge clk); checkOutput("rst pre bus_req", bus_req, 1'b1);
        step(); rst = 1'b0; applyStimulus(1, 0, 32'd1040, 0, 1, 32'h99999999);
        @(negedge clk);
        checkOutput("rst bus_req", bus_req, 1'b0);
        checkOutput("rst out", out, 32'h0);
        step(); applyStimulus(1, 0, 32'd1040, 0, 1, 32'h11112222);
        @(negedge clk); checkOutput("rst reissue bus_req", bus_req, 1'b1);
        step(); applyStimulus(1, 0, 32'd1040, 0, 0, 0);
        @(negedge clk); checkOutput("rst reissue out", out, 32'h11112222);
        step(); applyStimulus(0, 0, 0, 0, 0, 0);

        // Unanswered read
        step(); applyStimulus(1, 0, 32'd2048, 0, 0, 0);
`ifdef MEM_BUS_TIMEOUT_EN
        n = 0;
        @(negedge clk);
        while (!ready && n < 40) begin
            step(); n++;
            @(negedge clk);
        end
        checkOutput("tmo latency", n, 9);
        checkOutput("tmo err", err, 1'b1);
        checkOutput("tmo out", out, 32'h0);
        step(); applyStimulus(0, 0, 0, 0, 0, 0);
        @(negedge clk); checkOutput("tmo err pulse", err, 1'b0);
`else
        low = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            @(negedge clk);
            if (!ready) low++;
        end
        checkOutput("no tmo ready low cycles", low, 20);
        checkOutput("no tmo err", err, 1'b0);
        applyStimulus(1, 0, 32'd2048, 0, 1, 32'h00000055);
        step(); applyStimulus(1, 0, 32'd2048, 0, 0, 0);
        @(negedge clk); checkOutput("no tmo late out", out, 32'h00000055);
        step(); applyStimulus(0, 0, 0, 0, 0, 0);
`endif

        // Back-to-back reads: REQ, DONE, IDLE, REQ
        step(); applyStimulus(1, 0, 32'd1024, 0, 0, 0);
        step(); applyStimulus(1, 0, 32'd1024, 0, 1, 32'h0000000A);
        @(negedge clk); checkOutput("b2b req1", bus_req, 1'b1);
        step(); applyStimulus(1, 0, 32'd1024, 0, 0, 0);
        @(negedge clk); checkOutput("b2b done1", bus_req, 1'b0);
        checkOutput("b2b out1", out, 32'h0000000A);
        step(); applyStimulus(1, 0, 32'd1028, 0, 0, 0);
        @(negedge clk); checkOutput("b2b idle", bus_req, 1'b0);
        step(); applyStimulus(1, 0, 32'd1028, 0, 1, 32'h0000000B);
        @(negedge clk);
        checkOutput("b2b req2", bus_req, 1'b1);
        checkOutput("b2b addr2", bus_addr, 32'd1);
        step(); applyStimulus(1, 0, 32'd1028, 0, 0, 0);
        @(negedge clk); checkOutput("b2b out2", out, 32'h0000000B);
        step(); applyStimulus(0, 0, 0, 0, 0, 0);

        // Address below base wraps modulo 2^32
        step(); applyStimulus(0, 1, 32'd4, 32'h0BADF00D, 0, 0);
        step(); applyStimulus(0, 1, 32'd4, 32'h0BADF00D, 1, 0);
        @(negedge clk); checkOutput("wrap bus_addr", bus_addr, 32'h3FFFFF01);
        step(); applyStimulus(0, 1, 32'd4, 32'h0BADF00D, 0, 0);
        step(); applyStimulus(0, 0, 0, 0, 0, 0);
        step(); step();

        checking = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
